// File: rtl/ebc_pkg.sv
// Shared types and helpers for the AER event encoder: event type, field widths
// and the one-hot grant decoder.
package ebc_pkg;

    typedef enum logic {EVT_PIXEL = 1'b0, EVT_WRAP = 1'b1} evt_type_e;

    localparam int OH_MAX   = 64;
    localparam int OH_IDX_W = 6;

    typedef struct packed {
        logic                valid;
        logic [OH_IDX_W-1:0] idx;
    } onehot_res_t;

    function automatic int calc_rw(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int calc_cw(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int calc_evt_w(input int ts_w, input int rows, input int cols);
        return 2 + ts_w + calc_rw(rows) + calc_cw(cols);
    endfunction

    // valid only when exactly one bit is set; idx is then that bit's position
    function automatic onehot_res_t onehot_to_bin(input logic [OH_MAX-1:0] vec);
        onehot_res_t res;
        int          ones;
        res  = '0;
        ones = 0;
        for (int i = 0; i < OH_MAX; i++) begin
            if (vec[i]) begin
                ones    = ones + 1;
                res.idx = OH_IDX_W'(i);
            end
        end
        res.valid = (ones == 1);
        return res;
    endfunction

endpackage

// File: rtl/ebc_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
// Push is honoured when not full, or when full and a pop happens the same cycle.
module ebc_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Head word shows zero while empty so the output is clean after reset
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/aer_event_encoder.sv
// Converts one-hot arbiter grants into timestamped address-event words, buffers
// them in a FWFT FIFO and inserts a marker word on every timestamp wrap.
module aer_event_encoder
    import ebc_pkg::*;
#(
    parameter int  ROWS         = 8,
    parameter int  COLS         = 8,
    parameter int  TS_W         = 16,
    parameter int  TICK_DIV     = 10,
    parameter int  DEPTH        = 16,
    parameter int  AFULL_MARGIN = 3,
    localparam int RW           = calc_rw(ROWS),
    localparam int CW           = calc_cw(COLS),
    localparam int EVT_W        = calc_evt_w(TS_W, ROWS, COLS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [ROWS-1:0]  x_gnt_i,
    input  logic [COLS-1:0]  y_gnt_i,
    input  logic             polarity_i,
    output logic             arb_enable_o,
    output logic [EVT_W-1:0] evt_data_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic             err_o,
    output logic [7:0]       drop_cnt_o
);

    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [EVT_W-1:0] WRAP_WORD = {EVT_WRAP, {(EVT_W-1){1'b0}}};

    logic [PW-1:0]    presc_q;
    logic [TS_W-1:0]  ts_q;
    logic             marker_pend_q, marker_pend_d;
    logic             hold_valid_q, hold_valid_d;
    logic [EVT_W-1:0] hold_data_q, hold_data_d;
    logic             err_q;
    logic [7:0]       drop_cnt_q;
    logic             arb_en_q;

    onehot_res_t      x_res, y_res;
    logic             unused_idx_bits;
    logic             grant_any, grant_ok, new_valid, malformed;
    logic [EVT_W-1:0] new_word;
    logic             presc_tc, ts_wrap;

    logic             fifo_push, fifo_pop, fifo_empty, fifo_full, can_write, drop;
    logic [EVT_W-1:0] fifo_wdata;
    logic [CNT_W-1:0] fifo_count;
    logic             room_ok;

    assign x_res           = onehot_to_bin(OH_MAX'(x_gnt_i));
    assign y_res           = onehot_to_bin(OH_MAX'(y_gnt_i));
    assign unused_idx_bits = ^{x_res.idx, y_res.idx};
    assign grant_any       = (|x_gnt_i) | (|y_gnt_i);
    assign grant_ok        = x_res.valid & y_res.valid;
    assign new_valid       = enable_i & grant_ok;
    assign malformed       = enable_i & grant_any & ~grant_ok;
    assign new_word        = {EVT_PIXEL, ts_q, polarity_i, x_res.idx[RW-1:0], y_res.idx[CW-1:0]};

    assign presc_tc = (presc_q == PW'(TICK_DIV - 1));
    assign ts_wrap  = enable_i & presc_tc & (&ts_q);

    assign fifo_pop  = evt_valid_o & evt_ready_i;
    assign can_write = ~fifo_full | fifo_pop;
    assign room_ok   = (DEPTH - int'(fifo_count)) > AFULL_MARGIN;

    // One FIFO write per cycle: pending marker, then held event, then new event
    always_comb begin
        fifo_push     = 1'b0;
        fifo_wdata    = new_word;
        marker_pend_d = marker_pend_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        drop          = 1'b0;
        if (marker_pend_q) begin
            fifo_wdata = WRAP_WORD;
            if (can_write) begin
                fifo_push     = 1'b1;
                marker_pend_d = 1'b0;
            end
            if (new_valid) begin
                if (!hold_valid_q) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = new_word;
                end else begin
                    drop = 1'b1;
                end
            end
        end else if (hold_valid_q) begin
            fifo_wdata = hold_data_q;
            if (can_write) begin
                fifo_push = 1'b1;
            end else begin
                drop = 1'b1;
            end
            hold_valid_d = new_valid;
            hold_data_d  = new_word;
        end else if (new_valid) begin
            if (can_write) begin
                fifo_push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        if (ts_wrap) begin
            marker_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q       <= '0;
            ts_q          <= '0;
            marker_pend_q <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            err_q         <= 1'b0;
            drop_cnt_q    <= '0;
            arb_en_q      <= 1'b0;
        end else begin
            if (enable_i) begin
                if (presc_tc) begin
                    presc_q <= '0;
                    ts_q    <= ts_q + TS_W'(1);
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
            marker_pend_q <= marker_pend_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            err_q         <= err_q | malformed | drop;
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            arb_en_q <= enable_i & ~hold_valid_q & room_ok;
        end
    end

    ebc_sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (evt_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign evt_valid_o  = ~fifo_empty;
    assign arb_enable_o = arb_en_q;
    assign err_o        = err_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule
